// File: rtl/rv32_decode_buffer.sv
// rtl/rv32_decode_buffer.sv - fetch-to-decode instruction buffer (optional bypass: RV32_DECODE_BUFFER_BYPASS_EN)
module rv32_decode_buffer #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_in,
  input  logic                         stall_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic [PC_WIDTH-1:0]          pc_in,
  input  logic [31:0]                  instr_in,
  input  logic                         exception_in,
  input  logic [3:0]                   exception_cause_in,
  input  logic                         branch_predicted_taken_in,
  output logic                         valid_out,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic [31:0]                  instr_out,
  output logic                         exception_out,
  output logic [3:0]                   exception_cause_out,
  output logic                         branch_predicted_taken_out,
  output logic [4:0]                   rs1_unreg_out,
  output logic [4:0]                   rs2_unreg_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
  logic [31:0]         instr_mem [DEPTH];
  logic                exc_mem   [DEPTH];
  logic [3:0]          cause_mem [DEPTH];
  logic                bp_mem    [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic stored_valid;
  logic full;
  logic bypass_sel;
  logic bypass_take;
  logic enq;
  logic deq;

  assign stored_valid = (count != '0);
  assign full         = (count == CW'(DEPTH));

  // Reset forces the visible status to the empty/not-ready state even before
  // the first clock edge has cleared the counter.
  assign ready_out = !reset && !full;
  assign count_out = reset ? '0 : count;

`ifdef RV32_DECODE_BUFFER_BYPASS_EN
  // An offer arriving at an empty buffer is presented to decode immediately.
  assign bypass_sel = !reset && !stored_valid && valid_in && !flush_in;
`else
  assign bypass_sel = 1'b0;
`endif

  // A bypassed entry that decode takes right away is never written.
  assign bypass_take = bypass_sel && !stall_in;
  assign valid_out   = !reset && (stored_valid || bypass_sel);
  assign deq         = !reset && stored_valid && !stall_in && !flush_in;
  assign enq         = !reset && valid_in && !full && !flush_in && !bypass_take;

  // Head selection: bypass input, stored head, or zeros when nothing is valid.
  always_comb begin
    pc_out                     = '0;
    instr_out                  = '0;
    exception_out              = 1'b0;
    exception_cause_out        = '0;
    branch_predicted_taken_out = 1'b0;
    if (bypass_sel) begin
      pc_out                     = pc_in;
      instr_out                  = instr_in;
      exception_out              = exception_in;
      exception_cause_out        = exception_cause_in;
      branch_predicted_taken_out = branch_predicted_taken_in;
    end else if (valid_out) begin
      pc_out                     = pc_mem[rd_ptr];
      instr_out                  = instr_mem[rd_ptr];
      exception_out              = exc_mem[rd_ptr];
      exception_cause_out        = cause_mem[rd_ptr];
      branch_predicted_taken_out = bp_mem[rd_ptr];
    end
  end

  assign rs1_unreg_out = instr_out[19:15];
  assign rs2_unreg_out = instr_out[24:20];

  // Entry storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr]    <= pc_in;
      instr_mem[wr_ptr] <= instr_in;
      exc_mem[wr_ptr]   <= exception_in;
      cause_mem[wr_ptr] <= exception_cause_in;
      bp_mem[wr_ptr]    <= branch_predicted_taken_in;
    end
  end

  // Pointers and occupancy; reset and flush both return to the empty state.
  always_ff @(posedge clk) begin
    if (reset || flush_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_decode_buffer.sv
// tb/tb_rv32_decode_buffer.sv - randomized queue-model bench for rv32_decode_buffer
module tb_rv32_decode_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush_in = 1'b0, stall_in = 1'b0, valid_in = 1'b0;
  logic ready_out, valid_out;
  logic [31:0] pc_in = '0, instr_in = '0;
  logic exception_in = 1'b0;
  logic [3:0] exception_cause_in = '0;
  logic branch_predicted_taken_in = 1'b0;
  logic [31:0] pc_out, instr_out;
  logic exception_out;
  logic [3:0] exception_cause_out;
  logic branch_predicted_taken_out;
  logic [4:0] rs1_unreg_out, rs2_unreg_out;
  logic [CW-1:0] count_out;

  rv32_decode_buffer #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush_in(flush_in), .stall_in(stall_in),
    .valid_in(valid_in), .ready_out(ready_out), .pc_in(pc_in), .instr_in(instr_in),
    .exception_in(exception_in), .exception_cause_in(exception_cause_in),
    .branch_predicted_taken_in(branch_predicted_taken_in),
    .valid_out(valid_out), .pc_out(pc_out), .instr_out(instr_out),
    .exception_out(exception_out), .exception_cause_out(exception_cause_out),
    .branch_predicted_taken_out(branch_predicted_taken_out),
    .rs1_unreg_out(rs1_unreg_out), .rs2_unreg_out(rs2_unreg_out),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

`ifdef RV32_DECODE_BUFFER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Entry layout: {pc[69:38], instr[37:6], exc[5], cause[4:1], bp[0]}
  logic [69:0] model_q[$];
  int checks = 0;
  int passes = 0;
  bit accepted;

  function automatic logic [69:0] pack(input logic [31:0] pc, input logic [31:0] ins,
                                       input logic e, input logic [3:0] c, input logic b);
    return {pc, ins, e, c, b};
  endfunction

  task automatic check_val(input string tag, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Drive one cycle (entered just after a falling edge), compare against the
  // queue model, then advance the model across the rising edge.
  task automatic step(input logic rst, input logic f, input logic s, input logic v,
                      input logic [31:0] pc, input logic [31:0] ins,
                      input logic e, input logic [3:0] c, input logic b);
    logic [69:0] exp_head;
    logic        exp_valid, exp_ready, byp;
    int          exp_count;
    reset = rst; flush_in = f; stall_in = s; valid_in = v;
    pc_in = pc; instr_in = ins; exception_in = e; exception_cause_in = c;
    branch_predicted_taken_in = b;
    #1;
    exp_head = '0; exp_valid = 1'b0; exp_ready = 1'b0; exp_count = 0;
    if (!rst) begin
      exp_count = model_q.size();
      exp_ready = (model_q.size() != DEPTH);
      if (model_q.size() != 0) begin
        exp_valid = 1'b1; exp_head = model_q[0];
      end else if (BYPASS && v && !f) begin
        exp_valid = 1'b1; exp_head = pack(pc, ins, e, c, b);
      end
    end
    check_val("valid_out", valid_out, exp_valid);
    check_val("ready_out", ready_out, exp_ready);
    check_val("count_out", count_out, exp_count);
    check_val("head", {pc_out, instr_out, exception_out, exception_cause_out,
                       branch_predicted_taken_out}, exp_head);
    check_val("rs1", rs1_unreg_out, exp_head[6+15 +: 5]);
    check_val("rs2", rs2_unreg_out, exp_head[6+20 +: 5]);
    @(posedge clk);
    accepted = 1'b0;
    if (rst || f) model_q.delete();
    else begin
      byp = BYPASS && model_q.size() == 0 && v && !s;
      if (byp) accepted = 1'b1;
      else begin
        if (v && model_q.size() != DEPTH) begin
          if (model_q.size() != 0 && !s) void'(model_q.pop_front());
          model_q.push_back(pack(pc, ins, e, c, b));
          accepted = 1'b1;
        end else if (model_q.size() != 0 && !s) void'(model_q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic s);
    step(1'b0, 1'b0, s, 1'b0, '0, '0, 1'b0, 4'h0, 1'b0);
  endtask

  logic [31:0] fill_instr [4];
  logic [31:0] next_pc;
  logic [31:0] cyc_ins;

  initial begin
    fill_instr[0] = 32'h00000013; fill_instr[1] = 32'h00100093;
    fill_instr[2] = 32'h00200113; fill_instr[3] = 32'h00300193;
    @(negedge clk);
    // Reset held two cycles, then idle
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 4'h0, 1'b0);
    idle(1'b0);

    // Fill with decode stalled, one extra offer rejected, then drain
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'(i*4), fill_instr[i], 1'b0, 4'h0, 1'b0);
    check_val("fill_count", count_out, 4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h00400213, 1'b0, 4'h0, 1'b0);
    check_val("fifth_rejected", accepted, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);

    // Streaming with stall toggling every 3 cycles
    next_pc = 32'h200;
    for (int i = 0; i < 30; i++) begin
      cyc_ins = $urandom;
      step(1'b0, 1'b0, ((i / 3) % 2) == 1, next_pc < 32'h228, next_pc, cyc_ins,
           1'b0, 4'h0, 1'b0);
      if (accepted && next_pc < 32'h228) next_pc = next_pc + 4;
    end
    check_val("stream_all_accepted", next_pc, 32'h228);

    // Flush with three entries and a concurrent offer
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h300 + 32'(i*4), $urandom, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h3F0, $urandom, 1'b0, 4'h0, 1'b0);
    check_val("flush_count", count_out, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h00500293, 1'b0, 4'h0, 1'b0);
    idle(1'b0);

    // Metadata path
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 32'h00000073, 1'b1, 4'h1, 1'b1);
    idle(1'b0);
    idle(1'b0);

    // Empty buffer offer with decode ready (same-cycle in bypass build)
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h00a00513, 1'b0, 4'h0, 1'b0);
    idle(1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
           $urandom, $urandom, 1'($urandom), 4'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
